// File: rtl/adder_4bit_pkg.sv
// Shared constants, result type and overflow helper for the registered adder.
// Overflow logic is only used when ADDER_4BIT_OVF_EN is defined.
package adder_4bit_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef logic [DEFAULT_WIDTH:0] result_t;

    // Two's-complement overflow: like-signed operands produced an opposite-signed sum.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/adder_4bit_full_adder.sv
// Single-bit full adder cell; one instance per bit of the ripple-carry chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/adder_4bit.sv
// Ripple-carry adder with a single registered output stage and valid pipe.
// Define ADDER_4BIT_OVF_EN to add the registered signed-overflow output Ovf.
module adder_4bit
    import adder_4bit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             out_valid
`ifdef ADDER_4BIT_OVF_EN
    ,
    output logic             Ovf
`endif
);

    logic [WIDTH:0]   carry_s;
    logic [WIDTH-1:0] sum_s;

    assign carry_s[0] = Cin;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_fa
            full_adder u_fa (
                .a  (A[i]),
                .b  (B[i]),
                .ci (carry_s[i]),
                .s  (sum_s[i]),
                .co (carry_s[i+1])
            );
        end
    endgenerate

    // Result register: loads only on accepted inputs, valid follows in_valid every edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Sum       <= '0;
            Cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Sum  <= sum_s;
                Cout <= carry_s[WIDTH];
            end else begin
                Sum  <= Sum;
                Cout <= Cout;
            end
        end
    end

`ifdef ADDER_4BIT_OVF_EN
    logic ovf_s;

    assign ovf_s = signed_ovf(A[WIDTH-1], B[WIDTH-1], sum_s[WIDTH-1]);

    // Overflow flag register, loaded alongside Sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Ovf <= 1'b0;
        end else if (in_valid) begin
            Ovf <= ovf_s;
        end else begin
            Ovf <= Ovf;
        end
    end
`endif

endmodule

// File: tb/tb_adder_4bit.sv
// Self-checking bench for adder_4bit: directed corner cases plus randomized traffic
// against an arithmetic reference. Ovf is checked when ADDER_4BIT_OVF_EN is defined.
module tb_adder_4bit;

    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic       Cin;
    logic       in_valid;
    logic [3:0] Sum;
    logic       Cout;
    logic       out_valid;
`ifdef ADDER_4BIT_OVF_EN
    logic       Ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int exp_res  = 0;
    bit exp_ovf  = 1'b0;

    adder_4bit #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .in_valid  (in_valid),
        .Sum       (Sum),
        .Cout      (Cout),
        .out_valid (out_valid)
`ifdef ADDER_4BIT_OVF_EN
        ,
        .Ovf       (Ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input bit exp_valid);
        check({tag, ".sum"}, 32'(Sum), 32'(exp_res[3:0]));
        check({tag, ".cout"}, 32'(Cout), 32'(exp_res[4]));
        check({tag, ".valid"}, 32'(out_valid), 32'(exp_valid));
`ifdef ADDER_4BIT_OVF_EN
        check({tag, ".ovf"}, 32'(Ovf), 32'(exp_ovf));
`endif
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    task automatic step(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic cin, input logic v);
        int sa;
        int sb;
        int ss;
        A        = a;
        B        = b;
        Cin      = cin;
        in_valid = v;
        if (v) begin
            exp_res = int'(a) + int'(b) + int'(cin);
            sa      = (int'(a) >= 8) ? int'(a) - 16 : int'(a);
            sb      = (int'(b) >= 8) ? int'(b) - 16 : int'(b);
            ss      = sa + sb + int'(cin);
            exp_ovf = (ss > 7) || (ss < -8);
        end
        @(posedge clk);
        #1;
        check_outputs(tag, v);
    endtask

    initial begin
        rst      = 1'b1;
        A        = 4'b0000;
        B        = 4'b0000;
        Cin      = 1'b0;
        in_valid = 1'b0;
        #2;
        // Reset applied before any clock edge must clear outputs immediately.
        check_outputs("reset_idle", 1'b0);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("post_reset", 1'b0);

        step("zero",      4'b0000, 4'b0000, 1'b0, 1'b1);
        step("b2b_1",     4'b1011, 4'b0100, 1'b0, 1'b1);
        step("b2b_2",     4'b1111, 4'b1101, 1'b1, 1'b1);
        step("pos_ovf",   4'b0111, 4'b0001, 1'b0, 1'b1);
        step("neg_ovf",   4'b1000, 4'b1000, 1'b0, 1'b1);
        step("cin_ovf",   4'b0111, 4'b0000, 1'b1, 1'b1);

        step("hold_src",  4'b0101, 4'b0110, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step("hold", 4'($urandom), 4'($urandom), 1'($urandom), 1'b0);
        end

        // Asynchronous reset pulsed between edges discards the pending operation.
        step("pre_rst",   4'b1001, 4'b0011, 1'b0, 1'b1);
        A        = 4'b1111;
        B        = 4'b1111;
        Cin      = 1'b1;
        in_valid = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        exp_res = 0;
        exp_ovf = 1'b0;
        check_outputs("mid_rst", 1'b0);
        #1;
        rst = 1'b0;
        #1;
        check_outputs("mid_rst_rel", 1'b0);
        step("post_rst",  4'b1111, 4'b1111, 1'b1, 1'b1);
        check("post_rst.sum_lit", 32'(Sum), 32'd15);
        check("post_rst.cout_lit", 32'(Cout), 32'd1);

        for (int i = 0; i < 200; i++) begin
            step("rand", 4'($urandom), 4'($urandom), 1'($urandom),
                 1'($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
